// File: rtl/bcd_subtractor_seq.sv
// Two-digit BCD subtractor with start/done handshake: returns |A-B| as BCD digits,
// a sign flag for A < B, and an error flag when any latched digit exceeds 9.
module bcd_subtractor_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A1,
  input  logic [3:0] A0,
  input  logic [3:0] B1,
  input  logic [3:0] B0,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       neg,
  output logic       err,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SUB0,
    S_SUB1,
    S_DONE
  } state_t;

  state_t state, state_nx;
  logic   take;

  logic [3:0] a1, a0, b1, b0;
  logic [3:0] x1, x0, y1, y0;
  logic [3:0] d0_r;
  logic       borrow, sign, err_f;

  logic              a_lt_b, bad_digit;
  logic signed [4:0] t0, t0_adj, t1;

  assign a_lt_b    = (a1 < b1) || ((a1 == b1) && (a0 < b0));
  assign bad_digit = (a1 > 4'd9) || (a0 > 4'd9) || (b1 > 4'd9) || (b0 > 4'd9);

  assign t0     = signed'({1'b0, x0}) - signed'({1'b0, y0});
  assign t0_adj = t0 + 5'sd10;
  assign t1     = signed'({1'b0, x1}) - signed'({1'b0, y1}) - signed'({4'b0000, borrow});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // A request seen in DONE is accepted directly so a held start yields one
  // operation every 4 clocks.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          take     = 1'b1;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: state_nx = S_SUB0;
      S_SUB0:  state_nx = S_SUB1;
      S_SUB1:  state_nx = S_DONE;
      S_DONE: begin
        if (start) begin
          take     = 1'b1;
          state_nx = S_CHECK;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1     <= '0;
      a0     <= '0;
      b1     <= '0;
      b0     <= '0;
      x1     <= '0;
      x0     <= '0;
      y1     <= '0;
      y0     <= '0;
      d0_r   <= '0;
      borrow <= 1'b0;
      sign   <= 1'b0;
      err_f  <= 1'b0;
      D1     <= '0;
      D0     <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (take) begin
        a1 <= A1;
        a0 <= A0;
        b1 <= B1;
        b0 <= B0;
      end
      unique case (state)
        S_CHECK: begin
          err_f <= bad_digit;
          sign  <= a_lt_b;
          if (a_lt_b) begin
            x1 <= b1;
            x0 <= b0;
            y1 <= a1;
            y0 <= a0;
          end else begin
            x1 <= a1;
            x0 <= a0;
            y1 <= b1;
            y0 <= b0;
          end
        end
        S_SUB0: begin
          if (t0[4]) begin
            d0_r   <= t0_adj[3:0];
            borrow <= 1'b1;
          end else begin
            d0_r   <= t0[3:0];
            borrow <= 1'b0;
          end
        end
        S_SUB1: begin
          if (err_f) begin
            D1  <= '0;
            D0  <= '0;
            neg <= 1'b0;
            err <= 1'b1;
          end else begin
            D1  <= t1[3:0];
            D0  <= d0_r;
            neg <= sign;
            err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_subtractor_seq.sv
// Self-checking bench for bcd_subtractor_seq: directed table, handshake/reset
// sequences and randomized operations against a decimal-arithmetic model.
module tb_bcd_subtractor_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A1, A0, B1, B0;
  logic [3:0] D1, D0;
  logic       neg, err, busy, done;

  int checks;
  int errors;

  bcd_subtractor_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A1    (A1),
    .A0    (A0),
    .B1    (B1),
    .B0    (B0),
    .D1    (D1),
    .D0    (D0),
    .neg   (neg),
    .err   (err),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a1, a0, b1, b0;
    int d1, d0, n, e;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain decimal subtraction of the two-digit numbers.
  function automatic void model(input int a1, input int a0, input int b1, input int b0,
                                output int d1, output int d0, output int n, output int e);
    int a, b, diff;
    if (a1 > 9 || a0 > 9 || b1 > 9 || b0 > 9) begin
      d1 = 0; d0 = 0; n = 0; e = 1;
    end else begin
      a    = a1 * 10 + a0;
      b    = b1 * 10 + b0;
      diff = a - b;
      n    = (diff < 0) ? 1 : 0;
      if (diff < 0) diff = -diff;
      d1 = diff / 10;
      d0 = diff % 10;
      e  = 0;
    end
  endfunction

  task automatic chk_result(input string nm, input int d1, input int d0, input int n, input int e);
    chk({nm, ".D1"}, int'(D1), d1);
    chk({nm, ".D0"}, int'(D0), d0);
    chk({nm, ".neg"}, int'(neg), n);
    chk({nm, ".err"}, int'(err), e);
  endtask

  // One complete operation with per-cycle handshake checks; inputs are
  // scrambled after the start edge to confirm they are sampled only once.
  task automatic do_op(input string nm, input int a1, input int a0, input int b1, input int b0,
                       input int d1, input int d0, input int n, input int e);
    @(negedge clk);
    A1 = 4'(a1); A0 = 4'(a0); B1 = 4'(b1); B0 = 4'(b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A1 = 4'($urandom_range(0, 15)); A0 = 4'($urandom_range(0, 15));
    B1 = 4'($urandom_range(0, 15)); B0 = 4'($urandom_range(0, 15));
    chk({nm, ".busyN"}, int'(busy), 1);
    chk({nm, ".doneN"}, int'(done), 0);
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      chk({nm, ".busy"}, int'(busy), 1);
      chk({nm, ".done_early"}, int'(done), 0);
    end
    @(posedge clk); #1;
    chk({nm, ".busyN3"}, int'(busy), 1);
    chk({nm, ".doneN3"}, int'(done), 1);
    chk_result(nm, d1, d0, n, e);
    @(posedge clk); #1;
    chk({nm, ".doneN4"}, int'(done), 0);
    chk({nm, ".busyN4"}, int'(busy), 0);
    chk_result({nm, ".hold"}, d1, d0, n, e);
  endtask

  initial begin
    int ops[12][4];
    int ed1, ed0, en, ee;
    int ra1, ra0, rb1, rb0;

    checks = 0;
    errors = 0;

    vecs[0] = '{5, 2, 1, 7, 3, 5, 0, 0};
    vecs[1] = '{1, 7, 5, 2, 3, 5, 1, 0};
    vecs[2] = '{3, 0, 0, 5, 2, 5, 0, 0};
    vecs[3] = '{4, 0, 4, 0, 0, 0, 0, 0};
    vecs[4] = '{9, 9, 0, 0, 9, 9, 0, 0};
    vecs[5] = '{0, 0, 9, 9, 9, 9, 1, 0};
    vecs[6] = '{9, 10, 1, 1, 0, 0, 0, 1};
    vecs[7] = '{2, 1, 1, 1, 1, 0, 0, 0};
    vecs[8] = '{6, 3, 2, 8, 3, 5, 0, 0};

    rst_n = 1'b0;
    start = 1'b0;
    A1 = '0; A0 = '0; B1 = '0; B0 = '0;
    #12;
    chk_result("reset", 0, 0, 0, 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a1, vecs[i].a0, vecs[i].b1, vecs[i].b0,
            vecs[i].d1, vecs[i].d0, vecs[i].n, vecs[i].e);

    // Extra start pulses at N+1 and N+2 must be ignored.
    @(negedge clk);
    A1 = 4'd5; A0 = 4'd2; B1 = 4'd1; B0 = 4'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A1 = 4'd9; A0 = 4'd9; B1 = 4'd0; B0 = 4'd0;
    @(posedge clk);
    @(negedge clk);
    A1 = 4'd0; A0 = 4'd1; B1 = 4'd8; B0 = 4'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("ignore.done", int'(done), 1);
    chk_result("ignore", 3, 5, 0, 0);
    @(posedge clk); #1;
    chk("ignore.idle", int'(busy), 0);
    @(posedge clk);

    // Start held high: samples at N, N+4, N+8 with operands changing every cycle.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++) ops[k][j] = $urandom_range(0, 9);
      A1 = 4'(ops[k][0]); A0 = 4'(ops[k][1]); B1 = 4'(ops[k][2]); B0 = 4'(ops[k][3]);
      start = 1'b1;
      @(posedge clk); #1;
      chk("b2b.busy", int'(busy), 1);
      chk($sformatf("b2b.done%0d", k), int'(done), (k % 4 == 3) ? 1 : 0);
      if (k % 4 == 3) begin
        model(ops[k-3][0], ops[k-3][1], ops[k-3][2], ops[k-3][3], ed1, ed0, en, ee);
        chk_result($sformatf("b2b%0d", k), ed1, ed0, en, ee);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b.end_busy", int'(busy), 0);

    do_op("pre_rst", 5, 2, 1, 7, 3, 5, 0, 0);

    // Reset in the middle of 52-17.
    @(negedge clk);
    A1 = 4'd5; A0 = 4'd2; B1 = 4'd1; B0 = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_result("midrst", 0, 0, 0, 0);
    chk("midrst.busy", int'(busy), 0);
    chk("midrst.done", int'(done), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("midrst.nodone", int'(done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    do_op("post_rst", 6, 3, 2, 8, 3, 5, 0, 0);

    // Randomized operations, occasionally with an out-of-range digit.
    for (int i = 0; i < 40; i++) begin
      ra1 = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      ra0 = $urandom_range(0, 9);
      rb1 = $urandom_range(0, 9);
      rb0 = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      model(ra1, ra0, rb1, rb0, ed1, ed0, en, ee);
      do_op($sformatf("rnd%0d", i), ra1, ra0, rb1, rb0, ed1, ed0, en, ee);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
